stim_sequencer: RTL and testbench
=================================

STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter IN_W, default 141: DUT input vector width (129..160).
REQ-002 Parameter OUT_W, default 159: DUT output vector width.
REQ-003 Parameter RST_CYCLES, default 2: DUT reset-phase length in clocks (>=1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  run request, honoured only in IDLE.
REQ-007 cycles  in  32  vector count, sampled when start is accepted.
REQ-008 seed  in  32  LCG seed, sampled when start is accepted.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse at run completion.
REQ-011 dut_rst_n  out  1  DUT reset, active-low.
REQ-012 dut_ce  out  1  DUT clock enable.
REQ-013 in_flat  out  IN_W  vector applied to the DUT.
REQ-014 out_flat  in  OUT_W  DUT response.
REQ-015 log_valid / log_ready  out / in  1 / 1  log record handshake.
REQ-016 log_cyc, log_in, log_out  out  32, IN_W, OUT_W  record: vector index, applied vector, DUT response.

Function
REQ-017 The FSM SHALL have states IDLE, RESET, GEN, APPLY, LOG and DONE.
- IDLE to RESET on start when cycles != 0.
- IDLE to DONE on start when cycles == 0.
- RESET to GEN after RST_CYCLES clocks.
- GEN to APPLY after NW = ceil(IN_W/32) clocks.
- APPLY to LOG after 1 clock.
- LOG to GEN on log_valid&&log_ready when the vector count remains below cycles; otherwise LOG to DONE.
- DONE to IDLE after 1 clock.
REQ-018 The LCG step SHALL be s' = (s*32'h41C64E6D + 32'h3039) mod 2^32; the state loads from seed on start accept.
REQ-019 GEN SHALL perform one LCG step per clock.
- Step k (0-based) fills shadow bits [32k+31:32k].
- The final word keeps only bits [IN_W-1-32(NW-1):0] of s'.
REQ-020 APPLY SHALL copy the shadow register to in_flat and drive dut_ce=1 for exactly that clock.
REQ-021 in_flat SHALL change only on the edge entering APPLY.
REQ-022 dut_ce SHALL be 1 in RESET and APPLY and 0 elsewhere, so DUT state is frozen outside those states.
REQ-023 dut_rst_n SHALL be 0 in RESET and 1 in all other states.
REQ-024 In LOG, log_valid SHALL be 1.
- log_cyc = 0-based vector index.
- log_in = in_flat.
- log_out = out_flat, stable because the DUT is frozen.
REQ-025 The log record SHALL hold stable until log_ready; backpressure is unbounded.
REQ-026 Per-vector latency SHALL be NW+2 clocks with log_ready held high.
REQ-027 start while busy SHALL be ignored; cycles and seed SHALL NOT be resampled.
REQ-028 start and rst in the same cycle: rst wins.
REQ-029 The vector counter SHALL be 32-bit; cycles = 32'hFFFFFFFF SHALL complete without wrap.
REQ-030 done and log_valid SHALL never be high in the same cycle.

Reset
REQ-031 On rst the block SHALL enter IDLE.
- busy=0, done=0, dut_ce=0, dut_rst_n=0 (this clock only), log_valid=0.
- in_flat, log_cyc, shadow register and LCG state = 0.
REQ-032 rst mid-run SHALL abort in the next cycle with no done pulse and no partial log record.

Structure
REQ-033 Package stim_seq_pkg SHALL hold the state enum, LCG_MUL=32'h41C64E6D, LCG_INC=32'h3039 and DEFAULT_SEED=32'd3738645480.
REQ-034 The LCG step SHALL be a combinational sub-module lcg32_step, instantiated once.

Verification
REQ-035 seed=1, cycles=1, log_ready=1 -> first GEN word 32'h41C67EA6 appears in in_flat[31:0] at APPLY; exactly one log record with log_cyc=0.
REQ-036 cycles=3, RST_CYCLES=2, IN_W=141, log_ready=1, start at edge 0 -> RESET during clocks 1-2, APPLY at clocks 8, 15 and 22, done pulse at clock 24.
REQ-037 cycles=0 -> done pulses the clock after start; dut_rst_n stays 1, dut_ce stays 0, no log record.
REQ-038 log_ready held low 10 clocks in LOG -> log_valid stays 1 and log_in/log_out/log_cyc stay stable; dut_ce stays 0.
REQ-039 rst asserted during GEN of vector 1 of 3 -> IDLE next cycle, no done; a new start with seed=1 reproduces REQ-035's first word.
REQ-040 start pulsed while busy -> no effect; the count of applied vectors equals the originally sampled cycles.

Source files
------------

// File: rtl/stim_seq_pkg.sv
// stim_seq_pkg: shared state encoding and LCG constants for the stimulus sequencer.
package stim_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RESET, S_GEN, S_APPLY, S_LOG, S_DONE} state_t;
    localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC = 32'h3039;
    localparam logic [31:0] DEFAULT_SEED = 32'd3738645480;
endpackage

// File: rtl/lcg32_step.sv
// lcg32_step: one combinational step of the 32-bit linear congruential generator.
module lcg32_step
    import stim_seq_pkg::*;
(
    input  logic [31:0] s,
    output logic [31:0] n
);
    assign n = s * LCG_MUL + LCG_INC;
endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer: drives LCG-generated vectors into a clock-gated DUT and logs each response.
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter int IN_W       = 141,
    parameter int OUT_W      = 159,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      cycles,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic             done,
    output logic             dut_rst_n,
    output logic             dut_ce,
    output logic [IN_W-1:0]  in_flat,
    input  logic [OUT_W-1:0] out_flat,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [31:0]      log_cyc,
    output logic [IN_W-1:0]  log_in,
    output logic [OUT_W-1:0] log_out
);
    localparam int NW = (IN_W + 31) / 32;
    localparam int WW = $clog2(NW);

    state_t state, nxt;
    logic [31:0] cnt, cyc, rc, s, s_nxt;
    logic [WW-1:0] w;
    logic [IN_W-1:0] shadow, shadow_nxt, in_q;
    logic rst_n_q, last_w;

    lcg32_step u_lcg (.s(s), .n(s_nxt));

    assign last_w    = w == WW'(NW - 1);
    assign in_flat   = in_q;
    assign log_in    = in_q;
    assign log_out   = out_flat;
    assign log_cyc   = cnt;
    assign dut_rst_n = rst_n_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt       = state;
        busy      = state != S_IDLE;
        done      = state == S_DONE;
        dut_ce    = state == S_RESET || state == S_APPLY;
        log_valid = state == S_LOG;
        case (state)
            S_IDLE:  if (start) nxt = cycles == 32'd0 ? S_DONE : S_RESET;
            S_RESET: if (rc == 32'(RST_CYCLES - 1)) nxt = S_GEN;
            S_GEN:   if (last_w) nxt = S_APPLY;
            S_APPLY: nxt = S_LOG;
            S_LOG:   if (log_ready) nxt = cnt == cyc - 32'd1 ? S_DONE : S_GEN;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // The final word only has IN_W-32*(NW-1) slots, so its upper LCG bits fall away here.
    always_comb begin
        shadow_nxt = shadow;
        for (int b = 0; b < IN_W; b++)
            if (b / 32 == int'(w)) shadow_nxt[b] = s_nxt[b % 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cyc     <= '0;
            rc      <= '0;
            s       <= '0;
            w       <= '0;
            shadow  <= '0;
            in_q    <= '0;
            rst_n_q <= 1'b0;
        end else begin
            rst_n_q <= nxt != S_RESET;
            if (state == S_IDLE && start) begin
                cyc <= cycles;
                s   <= seed;
                cnt <= '0;
                rc  <= '0;
                w   <= '0;
            end
            if (state == S_RESET) rc <= rc + 32'd1;
            if (state == S_GEN) begin
                s      <= s_nxt;
                shadow <= shadow_nxt;
                w      <= last_w ? '0 : w + WW'(1);
                if (last_w) in_q <= shadow_nxt;
            end
            if (state == S_LOG && nxt == S_GEN) cnt <= cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: randomized directed runs against a behavioural sequencer model and a toy DUT.
module tb_stim_sequencer;
    localparam int IN_W = 141, OUT_W = 159, RST_CYCLES = 2, NW = (IN_W + 31) / 32;

    logic clk = 0, rst = 1, start = 0, log_ready = 0;
    logic [31:0] cycles = 0, seed = 0;
    logic busy, done, dut_rst_n, dut_ce, log_valid;
    logic [IN_W-1:0] in_flat, log_in;
    logic [OUT_W-1:0] out_flat, log_out;
    logic [31:0] log_cyc;

    int passed = 0, total = 0;
    logic [31:0] ms, first_word;
    logic [IN_W-1:0] cur_vec;
    logic [OUT_W-1:0] acc_exp;

    stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start), .cycles(cycles), .seed(seed),
        .busy(busy), .done(done), .dut_rst_n(dut_rst_n), .dut_ce(dut_ce),
        .in_flat(in_flat), .out_flat(out_flat), .log_valid(log_valid), .log_ready(log_ready),
        .log_cyc(log_cyc), .log_in(log_in), .log_out(log_out)
    );

    always #5 clk = ~clk;

    // Toy DUT: order-sensitive accumulator that only advances when clock-enabled.
    always @(posedge clk) begin
        if (!dut_rst_n) out_flat <= '0;
        else if (dut_ce) out_flat <= (out_flat << 1) ^ OUT_W'(in_flat);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic next_vec;
        cur_vec = '0;
        for (int j = 0; j < NW; j++) begin
            ms = ms * 32'h41C64E6D + 32'h3039;
            for (int b = 0; b < 32; b++)
                if (32 * j + b < IN_W) cur_vec[32 * j + b] = ms[b];
        end
    endtask

    // stall < 0: random log_ready; otherwise hold ready low for `stall` LOG cycles per record.
    task automatic do_run(input logic [31:0] n, input logic [31:0] sd, input int stall, input bit noise);
        int t, k, t_next, last_hs, lc;
        bit fin;
        ms = sd; k = 0; t_next = RST_CYCLES + NW + 1; last_hs = 0; lc = 0; fin = 0;
        if (n != 0) acc_exp = '0;
        start = 1; cycles = n; seed = sd; log_ready = 0;
        step;
        start = 0;
        t = 1;
        while (!fin && t < 3000) begin
            if (noise && $urandom_range(3) == 0) begin
                start = 1; cycles = $urandom_range(1, 9); seed = $urandom;
            end else start = 0;
            if (n == 0) begin
                chk("zero_rst_n", dut_rst_n, 1);
                chk("zero_ce", dut_ce, 0);
            end else if (t <= RST_CYCLES) begin
                chk("reset_phase_rst_n", dut_rst_n, 0);
                chk("reset_phase_ce", dut_ce, 1);
            end
            if (dut_ce && dut_rst_n) begin
                chk("apply_time", t, t_next);
                next_vec;
                acc_exp = (acc_exp << 1) ^ OUT_W'(cur_vec);
                if (k == 0) first_word = in_flat[31:0];
                chk("apply_vec", in_flat, cur_vec);
            end
            if (log_valid) begin
                chk("log_cyc", log_cyc, k);
                chk("log_in", log_in, cur_vec);
                chk("log_out", log_out, acc_exp);
                chk("log_ce", dut_ce, 0);
                log_ready = stall < 0 ? 1'($urandom_range(1)) : lc >= stall;
                if (log_ready) begin
                    k++; last_hs = t; t_next = t + NW + 1; lc = 0;
                end else lc++;
            end else log_ready = 1'($urandom_range(1));
            if (done) begin
                chk("done_records", k, n);
                chk("done_time", t, last_hs + 1);
                chk("done_excl", log_valid, 0);
                fin = 1;
                start = 0;
            end
            step;
            t++;
        end
        if (!fin) chk("run_timeout", 0, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        bit saw;
        rst = 1;
        step;
        step;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", dut_ce, 0);
        chk("rst_rst_n", dut_rst_n, 0);
        chk("rst_log_valid", log_valid, 0);
        chk("rst_in_flat", in_flat, 0);
        chk("rst_log_cyc", log_cyc, 0);
        rst = 0;
        step;
        chk("post_rst_rst_n", dut_rst_n, 1);

        do_run(1, 1, 0, 0);
        chk("first_word", first_word, 32'h41C67EA6);
        do_run(3, $urandom, 0, 0);
        do_run(0, $urandom, 0, 0);
        do_run(2, $urandom, 10, 0);
        do_run(4, $urandom, -1, 1);

        start = 1; cycles = 3; seed = $urandom; log_ready = 1;
        step;
        start = 0;
        for (int i = 0; i < 50 && !log_valid; i++) step;
        chk("abort_reach_log", log_valid, 1);
        step;
        step;
        rst = 1;
        step;
        rst = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_log_valid", log_valid, 0);
        chk("abort_in_flat", in_flat, 0);
        chk("abort_log_cyc", log_cyc, 0);
        chk("abort_rst_n", dut_rst_n, 0);
        saw = 0;
        for (int i = 0; i < 4; i++) begin
            saw |= done | log_valid | busy;
            step;
        end
        chk("abort_quiet", saw, 0);
        first_word = '0;
        do_run(1, 1, 0, 0);
        chk("first_word_again", first_word, 32'h41C67EA6);

        repeat (6) do_run($urandom_range(1, 5), $urandom, -1, 1'($urandom_range(1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
